// File: rtl/dp_run_sequencer_if.sv
// Handshake and datapath-control bundle between a host, the run sequencer
// and the KGP-RISC datapath. The sequencer attaches through the slave view.
interface dp_run_sequencer_if #(
  parameter int CNT_W = 16
);
  // host request side
  logic             start;
  logic             prog_sel;
  logic             abort;
  // datapath feedback
  logic             halt;
  logic [31:0]      res_a_in;
  logic [31:0]      res_b_in;
  // datapath control strobes
  logic             dp_reset;
  logic             mem_init;
  logic             pc_init;
  logic             sp_init;
  logic             gcd_load;
  logic             booth_load;
  logic             run_en;
  // host status and results
  logic             busy;
  logic             done;
  logic             timeout;
  logic [31:0]      res_a;
  logic [31:0]      res_b;
  logic [CNT_W-1:0] run_cycles;

  modport slave (
    input  start, prog_sel, abort, halt, res_a_in, res_b_in,
    output dp_reset, mem_init, pc_init, sp_init, gcd_load, booth_load,
           run_en, busy, done, timeout, res_a, res_b, run_cycles
  );

  modport master (
    output start, prog_sel, abort, halt, res_a_in, res_b_in,
    input  dp_reset, mem_init, pc_init, sp_init, gcd_load, booth_load,
           run_en, busy, done, timeout, res_a, res_b, run_cycles
  );
endinterface

// File: rtl/dp_run_sequencer.sv
// Sequences a single program run on the KGP-RISC datapath:
// init strobes, one program-select pulse, an enable window bounded by a
// cycle budget, then result capture. Every output is decoded from flops.
module dp_run_sequencer #(
  parameter int INIT_CYCLES    = 1,
  parameter int MAX_RUN_CYCLES = 500,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  dp_run_sequencer_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0]       INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_RUN_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [3:0]       init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             sel_q, sel_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      res_a_q, res_a_d;
  logic [31:0]      res_b_q, res_b_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;

  // Next-state, counters and result capture.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    run_cnt_d    = run_cnt_q;
    sel_d        = sel_q;
    timeout_d    = timeout_q;
    res_a_d      = res_a_q;
    res_b_d      = res_b_q;
    run_cycles_d = run_cycles_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // abort alongside start suppresses the start
        if (bus.start && !bus.abort) begin
          state_d    = S_INIT;
          sel_d      = bus.prog_sel;
          init_cnt_d = '0;
        end
      end
      S_INIT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (init_cnt_q == INIT_LAST) begin
          state_d = S_LOAD;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          // Counter already includes the first RUN cycle, so it reads k
          // during the k-th RUN cycle.
          state_d   = S_RUN;
          run_cnt_d = CNT_W'(1);
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.halt || (run_cnt_q == RUN_LAST)) begin
          // halt takes priority over budget expiry on the same edge
          state_d      = S_DONE;
          res_a_d      = bus.res_a_in;
          res_b_d      = bus.res_b_in;
          run_cycles_d = run_cnt_q;
          timeout_d    = !bus.halt;
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      init_cnt_q   <= '0;
      run_cnt_q    <= '0;
      sel_q        <= 1'b0;
      timeout_q    <= 1'b0;
      res_a_q      <= '0;
      res_b_q      <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      run_cnt_q    <= run_cnt_d;
      sel_q        <= sel_d;
      timeout_q    <= timeout_d;
      res_a_q      <= res_a_d;
      res_b_q      <= res_b_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Moore output decode; timeout is only meaningful while done.
  assign bus.dp_reset   = (state_q == S_INIT);
  assign bus.mem_init   = (state_q == S_INIT);
  assign bus.pc_init    = (state_q == S_INIT);
  assign bus.sp_init    = (state_q == S_INIT);
  assign bus.gcd_load   = (state_q == S_LOAD) && !sel_q;
  assign bus.booth_load = (state_q == S_LOAD) &&  sel_q;
  assign bus.run_en     = (state_q == S_RUN);
  assign bus.busy       = (state_q == S_INIT) || (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.timeout    = (state_q == S_DONE) && timeout_q;
  assign bus.res_a      = res_a_q;
  assign bus.res_b      = res_b_q;
  assign bus.run_cycles = run_cycles_q;

endmodule

// File: tb/tb_dp_run_sequencer.sv
// Directed bench for dp_run_sequencer. Two instances: A with one init
// cycle, B with three. Expected results go into a scoreboard queue when a
// run's stopping condition is driven and are checked when done rises.
module tb_dp_run_sequencer;

  logic clk;
  logic reset;

  logic        dsel;
  logic        start_r, prog_sel_r, abort_r, halt_r;
  logic [31:0] resa_r, resb_r;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] cyc;
    logic        to;
  } exp_t;
  exp_t sbq[$];
  logic [31:0] last_a;

  // flag order: dp_reset mem_init pc_init sp_init gcd booth run_en busy done timeout
  localparam logic [9:0] F_IDLE = 10'b0000_00_0_0_0_0;
  localparam logic [9:0] F_INIT = 10'b1111_00_0_1_0_0;
  localparam logic [9:0] F_LDG  = 10'b0000_10_0_1_0_0;
  localparam logic [9:0] F_RUN  = 10'b0000_00_1_1_0_0;

  dp_run_sequencer_if #(.CNT_W(16)) ifa ();
  dp_run_sequencer_if #(.CNT_W(16)) ifb ();

  dp_run_sequencer #(.INIT_CYCLES(1), .MAX_RUN_CYCLES(500), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  dp_run_sequencer #(.INIT_CYCLES(3), .MAX_RUN_CYCLES(500), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  assign ifa.start    = start_r & ~dsel;
  assign ifb.start    = start_r &  dsel;
  assign ifa.abort    = abort_r & ~dsel;
  assign ifb.abort    = abort_r &  dsel;
  assign ifa.halt     = halt_r  & ~dsel;
  assign ifb.halt     = halt_r  &  dsel;
  assign ifa.prog_sel = prog_sel_r;
  assign ifb.prog_sel = prog_sel_r;
  assign ifa.res_a_in = resa_r;
  assign ifb.res_a_in = resa_r;
  assign ifa.res_b_in = resb_r;
  assign ifb.res_b_in = resb_r;

  logic [9:0]  o_flags;
  logic [31:0] o_ra, o_rb;
  logic [15:0] o_rc;

  always_comb begin
    if (dsel) begin
      o_flags = {ifb.dp_reset, ifb.mem_init, ifb.pc_init, ifb.sp_init, ifb.gcd_load,
                 ifb.booth_load, ifb.run_en, ifb.busy, ifb.done, ifb.timeout};
      o_ra = ifb.res_a;
      o_rb = ifb.res_b;
      o_rc = ifb.run_cycles;
    end else begin
      o_flags = {ifa.dp_reset, ifa.mem_init, ifa.pc_init, ifa.sp_init, ifa.gcd_load,
                 ifa.booth_load, ifa.run_en, ifa.busy, ifa.done, ifa.timeout};
      o_ra = ifa.res_a;
      o_rb = ifa.res_b;
      o_rc = ifa.run_cycles;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic psel);
    prog_sel_r = psel;
    start_r    = 1'b1;
    tick();
    start_r    = 1'b0;
    prog_sel_r = ~psel;
  endtask

  // Called in the first INIT cycle; runs until done or the bound expires.
  task automatic run_to_done(input int halt_at, input int exp_init, input logic psel,
                             input int budget);
    int   n_init = 0;
    int   n_g    = 0;
    int   n_b    = 0;
    int   n_run  = 0;
    logic seen   = 1'b0;
    exp_t e;
    chk("init_entry", o_flags, F_INIT);
    resa_r = $urandom;
    resb_r = $urandom;
    if (halt_at == 0) sbq.push_back('{resa_r, resb_r, 16'(budget), 1'b1});
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (o_flags[1]) begin
        seen = 1'b1;
      end else begin
        if (o_flags[9:6] == 4'hF) n_init++;
        if (o_flags[5]) n_g++;
        if (o_flags[4]) n_b++;
        if (o_flags[3]) n_run++;
        if (o_flags[3] && halt_at != 0 && n_run == halt_at) begin
          halt_r = 1'b1;
          sbq.push_back('{resa_r, resb_r, 16'(halt_at), 1'b0});
        end
        tick();
        halt_r = 1'b0;
      end
    end
    chk("done_reached", 64'(seen), 64'd1);
    chk("init_cycles", 64'(n_init), 64'(exp_init));
    chk("gcd_pulses", 64'(n_g), psel ? 64'd0 : 64'd1);
    chk("booth_pulses", 64'(n_b), psel ? 64'd1 : 64'd0);
    chk("run_en_cycles", 64'(n_run), 64'((halt_at != 0) ? halt_at : budget));
    chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("res_a", o_ra, e.a);
      chk("res_b", o_rb, e.b);
      chk("run_cycles", o_rc, e.cyc);
      chk("timeout", o_flags[0], e.to);
      chk("busy_in_done", o_flags[2], 1'b0);
      last_a = e.a;
      resa_r = ~resa_r;
      tick();
      chk("done_hold", o_flags[1], 1'b1);
      chk("res_a_hold", o_ra, e.a);
    end
  endtask

  initial begin
    reset = 1'b1;
    dsel = 1'b0; start_r = 1'b0; prog_sel_r = 1'b0; abort_r = 1'b0; halt_r = 1'b0;
    resa_r = '0; resb_r = '0; last_a = '0;
    repeat (3) tick();
    chk("reset_flags_a", o_flags, F_IDLE);
    chk("reset_res_a", o_ra, 32'd0);
    chk("reset_cycles_a", o_rc, 16'd0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", o_flags, F_IDLE);

    // gcd run halted on RUN cycle 37
    launch(1'b0);
    run_to_done(37, 1, 1'b0, 500);

    // restart from DONE, ignored starts while busy, then abort in RUN cycle 10
    launch(1'b0);
    chk("done_drops_on_init", o_flags, F_INIT);
    prog_sel_r = 1'b1;
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    chk("no_relatch_load", o_flags, F_LDG);
    tick();
    for (int i = 1; i < 10; i++) begin
      if (i == 5) start_r = 1'b1;
      tick();
      start_r = 1'b0;
    end
    chk("run_c10_no_restart", o_flags, F_RUN);
    abort_r = 1'b1;
    tick();
    abort_r = 1'b0;
    chk("abort_idle", o_flags, F_IDLE);
    chk("abort_keeps_cycles", o_rc, 16'd37);
    chk("abort_keeps_res_a", o_ra, last_a);

    // abort with start in IDLE: start must be ignored
    abort_r = 1'b1;
    start_r = 1'b1;
    tick();
    abort_r = 1'b0;
    start_r = 1'b0;
    chk("abort_beats_start", o_flags, F_IDLE);

    // instance B: Booth with three init cycles, then timeout, then halt at budget
    dsel = 1'b1;
    tick();
    launch(1'b1);
    run_to_done(20, 3, 1'b1, 500);
    launch(1'b0);
    run_to_done(0, 3, 1'b0, 500);
    launch(1'b1);
    run_to_done(500, 3, 1'b1, 500);

    // asynchronous reset in the middle of a run on instance A
    dsel = 1'b0;
    tick();
    launch(1'b0);
    repeat (12) tick();
    chk("pre_reset_run", o_flags, F_RUN);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset_flags", o_flags, F_IDLE);
    chk("async_reset_res_a", o_ra, 32'd0);
    chk("async_reset_cycles", o_rc, 16'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("idle_after_async", o_flags, F_IDLE);
    launch(1'b0);
    run_to_done(5, 1, 1'b0, 500);
    launch(1'b1);
    run_to_done(8, 1, 1'b1, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
